mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single memory port between dcache (loads + write-through stores) and icache (loads).
// - Sits between both caches and mem; forwards the granted request and routes mem2proc_response to the granted cache.
// - Records which cache owns each outstanding load tag and steers the returned data/tag to that cache only.
// - Dcache has priority; an anti-starvation counter guarantees icache progress.
// PARAMETERS
// - XLEN          32  address width
// - NUM_TAGS      16  memory tag space; tag 0 = "no tag"; must be 2**4
// - STARVE_LIMIT  4   consecutive denied icache-request cycles before icache gets forced priority
// PORTS
// - clock              in   1     single clock; all state updates on posedge
// - reset              in   1     asynchronous, ACTIVE-LOW (0 = reset)
// - dcache_command     in   2     BUS_NONE / BUS_LOAD / BUS_STORE
// - dcache_addr        in   XLEN  dcache request address
// - dcache_wdata       in   64    store data
// - dcache_response    out  4     nonzero tag = request accepted this cycle; 0 = retry
// - dcache_rdata       out  64    load return data, valid when dcache_tag != 0
// - dcache_tag         out  4     returned tag owned by dcache, else 0
// - icache_command     in   2     BUS_NONE / BUS_LOAD only (BUS_STORE is treated as BUS_NONE)
// - icache_addr        in   XLEN  icache request address
// - icache_response    out  4     as dcache_response
// - icache_rdata       out  64    as dcache_rdata
// - icache_tag         out  4     as dcache_tag
// - proc2mem_command   out  2     to memory
// - proc2mem_addr      out  XLEN  to memory
// - proc2mem_data      out  64    to memory (dcache_wdata when dcache is granted, else 0)
// - mem2proc_response  in   4     acceptance tag from memory, same cycle as the command
// - mem2proc_data      in   64    returned load data
// - mem2proc_tag       in   4     returned load tag
// - tag_err            out  1     sticky: a returned tag had no owner, or an allocated tag was still valid
// BEHAVIOUR
// - Grant is combinational each cycle. If only one cache requests, that cache is granted.
// - If both request, dcache is granted unless starve_cnt == STARVE_LIMIT, in which case icache is granted.
// - Request path: proc2mem_* = the granted cache's request; BUS_NONE/0/0 when no cache requests.
// - Response path: granted cache's response = mem2proc_response; the non-granted cache's response = 0.
// - starve_cnt (posedge): reset to 0 when icache is granted or icache is not requesting;
//   incremented (saturating at STARVE_LIMIT) when icache requests but is denied.
// - Owner table: NUM_TAGS entries of {valid, owner (0 = dcache, 1 = icache)}.
//   - Allocate at posedge when the granted command is BUS_LOAD and mem2proc_response != 0.
//   - Stores are not recorded; memory returns no data for stores.
// - Return path (combinational): if mem2proc_tag != 0 and its entry is valid,
//   the owner's tag/rdata = mem2proc_tag/mem2proc_data and the other cache's tag = 0.
//   - The entry is cleared at posedge.
//   - If the entry is invalid: both tags = 0, and tag_err is set at posedge.
// - Same tag returned and re-allocated in the same cycle: clear first, then allocate (the new owner wins; no error).
// - Allocating a tag that is still valid (not freed in the same cycle): overwrite the entry and set tag_err.
// - Reset asserted (async, any time, including mid-transaction): owner table invalid, starve_cnt = 0, tag_err = 0.
//   While reset is low, all outputs are forced to 0 / BUS_NONE.
//   Tags still in flight across reset are dropped and raise tag_err after reset deasserts.
// - Latency: zero added cycles on both the request and return paths; no buffering inside this block.
// STRUCTURE
// - sys_defs.svh: BUS_COMMAND enum (BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2) and a MEM_OWNER enum (OWN_DCACHE, OWN_ICACHE).
// - Sub-module mem_tag_owner_table: NUM_TAGS-entry valid/owner array.
//   - One allocate port and one lookup/free port.
//   - Outputs hit and owner for the lookup tag.
// - The top level holds the grant logic, starve_cnt, output muxes and tag_err.
// TESTING
// - Dcache-only load of 0x10 (mem returns response 3):
//   dcache_response = 3, icache_response = 0; later mem2proc_tag = 3 gives dcache_tag = 3, icache_tag = 0.
// - Both request loads for 5 cycles, mem always accepting:
//   dcache granted cycles 0-3, icache granted cycle 4, starve_cnt returns to 0.
// - Dcache store addr 0x8, data 0x18:
//   proc2mem_command = BUS_STORE, proc2mem_data = 0x18, no table entry; a later tag return for it sets tag_err.
// - Icache load gets tag 5; in the cycle tag 5 returns, dcache load is granted tag 5:
//   icache_tag = 5 that cycle, entry 5 then owned by dcache, tag_err = 0.
// - Memory busy (mem2proc_response = 0) while dcache requests:
//   dcache_response = 0, no allocation, starve_cnt unaffected by dcache.
// - Assert reset mid-flight with 2 tags outstanding:
//   outputs immediately 0, table cleared; returned tags after release give tag = 0 to both caches and tag_err = 1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: bus command encoding and tag owner encoding.
package mem_port_arbiter_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_e;

  typedef enum logic {
    OWN_DCACHE = 1'b0,
    OWN_ICACHE = 1'b1
  } mem_owner_e;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Valid/owner record for every outstanding memory load tag.
// One allocate port and one lookup/free port; a free and an allocate of the
// same tag in one cycle resolve as free-then-allocate, so the new owner wins.
module mem_tag_owner_table
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             alloc_owner,
  input  logic [TAG_W-1:0] lookup_tag,
  input  logic             free_en,
  output logic             hit,
  output logic             owner,
  output logic             alloc_busy
);

  logic [NUM_TAGS-1:0] valid_q;
  logic [NUM_TAGS-1:0] owner_q;
  logic                freeing;

  // Lookup of the returning tag; tag 0 means "no tag" and never hits.
  always_comb begin
    hit        = (lookup_tag != '0) && valid_q[lookup_tag];
    owner      = owner_q[lookup_tag];
    freeing    = free_en && hit;
    alloc_busy = alloc_en && valid_q[alloc_tag] && !(freeing && (lookup_tag == alloc_tag));
  end

  // Free the returned entry, then allocate; the later assignment wins on a shared tag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      if (freeing) begin
        valid_q[lookup_tag] <= 1'b0;
      end
      if (alloc_en) begin
        valid_q[alloc_tag] <= 1'b1;
        owner_q[alloc_tag] <= alloc_owner;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between dcache and icache. Dcache has priority;
// a starvation counter forces an icache grant after STARVE_LIMIT denials.
// Returned load data is steered to whichever cache owns the tag.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        dcache_command,
  input  logic [XLEN-1:0]   dcache_addr,
  input  logic [DATA_W-1:0] dcache_wdata,
  output logic [TAG_W-1:0]  dcache_response,
  output logic [DATA_W-1:0] dcache_rdata,
  output logic [TAG_W-1:0]  dcache_tag,
  input  logic [1:0]        icache_command,
  input  logic [XLEN-1:0]   icache_addr,
  output logic [TAG_W-1:0]  icache_response,
  output logic [DATA_W-1:0] icache_rdata,
  output logic [TAG_W-1:0]  icache_tag,
  output logic [1:0]        proc2mem_command,
  output logic [XLEN-1:0]   proc2mem_addr,
  output logic [DATA_W-1:0] proc2mem_data,
  input  logic [TAG_W-1:0]  mem2proc_response,
  input  logic [DATA_W-1:0] mem2proc_data,
  input  logic [TAG_W-1:0]  mem2proc_tag,
  output logic              tag_err
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             d_req;
  logic             i_req;
  logic             grant_d;
  logic             grant_i;
  logic             alloc_en;
  logic             ret_valid;
  logic             hit;
  logic             owner;
  logic             alloc_busy;

  mem_tag_owner_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_owner_table (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_tag   (mem2proc_response),
    .alloc_owner (grant_i),
    .lookup_tag  (mem2proc_tag),
    .free_en     (ret_valid),
    .hit         (hit),
    .owner       (owner),
    .alloc_busy  (alloc_busy)
  );

  // Grant, request/response muxing and return steering; everything is zero while in reset.
  always_comb begin
    d_req            = (dcache_command == BUS_LOAD) || (dcache_command == BUS_STORE);
    i_req            = (icache_command == BUS_LOAD);
    grant_i          = reset && i_req && (!d_req || (starve_cnt == CNT_W'(STARVE_LIMIT)));
    grant_d          = reset && d_req && !grant_i;
    ret_valid        = reset && (mem2proc_tag != '0);
    alloc_en         = 1'b0;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    dcache_response  = '0;
    icache_response  = '0;
    dcache_tag       = '0;
    dcache_rdata     = '0;
    icache_tag       = '0;
    icache_rdata     = '0;
    if (grant_d) begin
      proc2mem_command = dcache_command;
      proc2mem_addr    = dcache_addr;
      proc2mem_data    = dcache_wdata;
      dcache_response  = mem2proc_response;
      alloc_en         = (dcache_command == BUS_LOAD) && (mem2proc_response != '0);
    end else if (grant_i) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = icache_addr;
      icache_response  = mem2proc_response;
      alloc_en         = (mem2proc_response != '0);
    end
    if (ret_valid && hit) begin
      if (owner == OWN_ICACHE) begin
        icache_tag   = mem2proc_tag;
        icache_rdata = mem2proc_data;
      end else begin
        dcache_tag   = mem2proc_tag;
        dcache_rdata = mem2proc_data;
      end
    end
  end

  // Count consecutive icache denials, saturating at the limit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!i_req || grant_i) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Sticky error: orphan tag returned, or a still-live tag handed out again.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_err <= 1'b0;
    end else if ((ret_valid && !hit) || alloc_busy) begin
      tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a scoreboard monitor on the
// response/tag outputs plus direct checks of the request path and tag_err.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clock;
  logic        reset;
  logic [1:0]  dcache_command;
  logic [31:0] dcache_addr;
  logic [63:0] dcache_wdata;
  logic [3:0]  dcache_response;
  logic [63:0] dcache_rdata;
  logic [3:0]  dcache_tag;
  logic [1:0]  icache_command;
  logic [31:0] icache_addr;
  logic [3:0]  icache_response;
  logic [63:0] icache_rdata;
  logic [3:0]  icache_tag;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic        tag_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          port;
    logic [3:0]  tag;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];

  mem_port_arbiter #(
    .XLEN         (32),
    .NUM_TAGS     (16),
    .STARVE_LIMIT (4)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .dcache_command    (dcache_command),
    .dcache_addr       (dcache_addr),
    .dcache_wdata      (dcache_wdata),
    .dcache_response   (dcache_response),
    .dcache_rdata      (dcache_rdata),
    .dcache_tag        (dcache_tag),
    .icache_command    (icache_command),
    .icache_addr       (icache_addr),
    .icache_response   (icache_response),
    .icache_rdata      (icache_rdata),
    .icache_tag        (icache_tag),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .tag_err           (tag_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: every nonzero response/tag output must match the next expected entry.
  logic [3:0]  mon_v [4];
  logic [63:0] mon_d [4];
  always @(negedge clock) begin
    mon_v[0] = dcache_response; mon_d[0] = 64'd0;
    mon_v[1] = icache_response; mon_d[1] = 64'd0;
    mon_v[2] = dcache_tag;      mon_d[2] = dcache_rdata;
    mon_v[3] = icache_tag;      mon_d[3] = icache_rdata;
    for (int p = 0; p < 4; p++) begin
      if (mon_v[p] != 4'd0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out port=%0d got tag=%0d data=%h, required no output", p, mon_v[p], mon_d[p]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.port != p || e.tag != mon_v[p] || e.data != mon_d[p]) begin
            errors++;
            $display("FAIL scoreboard got port=%0d tag=%0d data=%h, required port=%0d tag=%0d data=%h",
                     p, mon_v[p], mon_d[p], e.port, e.tag, e.data);
          end
        end
      end
    end
    while (exp_q.size() != 0) begin
      exp_t m;
      m = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_out got nothing, required port=%0d tag=%0d data=%h", m.port, m.tag, m.data);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  task automatic expect_out(input int p, input logic [3:0] t, input logic [63:0] d);
    exp_t e;
    e.port = p; e.tag = t; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dw,
                       input logic [1:0] ic, input logic [31:0] ia,
                       input logic [3:0] mr, input logic [3:0] mt, input logic [63:0] md);
    @(posedge clock);
    #1;
    dcache_command = dc; dcache_addr = da; dcache_wdata = dw;
    icache_command = ic; icache_addr = ia;
    mem2proc_response = mr; mem2proc_tag = mt; mem2proc_data = md;
  endtask

  task automatic idle();
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #2 reset = 1'b0;
    #1 chk("reset_tag_err", 64'(tag_err), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    dcache_command = BUS_LOAD; dcache_addr = 32'h44; dcache_wdata = 64'h77;
    icache_command = BUS_LOAD; icache_addr = 32'h88;
    mem2proc_response = 4'd3; mem2proc_tag = 4'd2; mem2proc_data = 64'h99;

    // Outputs forced to zero while reset is held, despite active inputs.
    @(negedge clock);
    chk("rst_cmd", 64'(proc2mem_command), 64'd0);
    chk("rst_addr", 64'(proc2mem_addr), 64'd0);
    chk("rst_data", proc2mem_data, 64'd0);
    chk("rst_tag_err", 64'(tag_err), 64'd0);
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clock);

    // Dcache-only load, tag 3, returned later.
    drive(BUS_LOAD, 32'h10, 0, BUS_NONE, 0, 3, 0, 0);
    expect_out(0, 3, 0);
    @(negedge clock);
    chk("t1_cmd", 64'(proc2mem_command), 64'(BUS_LOAD));
    chk("t1_addr", 64'(proc2mem_addr), 64'h10);
    idle();
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 3, 64'hAAAA_0000_1111_2222);
    expect_out(2, 3, 64'hAAAA_0000_1111_2222);
    @(negedge clock);
    idle();
    chk("t1_tag_err", 64'(tag_err), 64'd0);

    // Both request: dcache for 4 cycles, icache on the 5th, dcache again after.
    for (int k = 0; k < 6; k++) begin
      drive(BUS_LOAD, 32'h100, 64'h55, BUS_LOAD, 32'h200, 4'(k + 1), 0, 0);
      if (k == 4) expect_out(1, 4'(k + 1), 0);
      else        expect_out(0, 4'(k + 1), 0);
      @(negedge clock);
      chk("t2_addr", 64'(proc2mem_addr), (k == 4) ? 64'h200 : 64'h100);
      chk("t2_data", proc2mem_data, (k == 4) ? 64'h0 : 64'h55);
    end
    for (int t = 1; t <= 6; t++) begin
      drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'(t), 64'h100 + 64'(t));
      expect_out((t == 5) ? 3 : 2, 4'(t), 64'h100 + 64'(t));
      @(negedge clock);
    end
    idle();
    chk("t2_tag_err", 64'(tag_err), 64'd0);

    // Store is forwarded but not recorded; a return for its tag is an orphan.
    drive(BUS_STORE, 32'h8, 64'h18, BUS_NONE, 0, 7, 0, 0);
    expect_out(0, 7, 0);
    @(negedge clock);
    chk("t3_cmd", 64'(proc2mem_command), 64'(BUS_STORE));
    chk("t3_data", proc2mem_data, 64'h18);
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 7, 64'h1);
    @(negedge clock);
    idle();
    chk("t3_tag_err", 64'(tag_err), 64'd1);
    pulse_reset();

    // Tag 5 returns to icache in the same cycle dcache is granted tag 5.
    drive(BUS_NONE, 0, 0, BUS_LOAD, 32'h300, 5, 0, 0);
    expect_out(1, 5, 0);
    @(negedge clock);
    drive(BUS_LOAD, 32'h400, 0, BUS_NONE, 0, 5, 5, 64'hBEEF);
    expect_out(0, 5, 0);
    expect_out(3, 5, 64'hBEEF);
    @(negedge clock);
    idle();
    chk("t4_tag_err_a", 64'(tag_err), 64'd0);
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 5, 64'hCAFE);
    expect_out(2, 5, 64'hCAFE);
    @(negedge clock);
    idle();
    chk("t4_tag_err_b", 64'(tag_err), 64'd0);

    // Memory busy: request forwarded, response 0, nothing allocated.
    drive(BUS_LOAD, 32'h500, 0, BUS_NONE, 0, 0, 0, 0);
    @(negedge clock);
    chk("t5_cmd", 64'(proc2mem_command), 64'(BUS_LOAD));
    chk("t5_resp", 64'(dcache_response), 64'd0);
    idle();
    chk("t5_tag_err", 64'(tag_err), 64'd0);

    // Reset mid-flight with tags 10 (dcache) and 11 (icache) outstanding.
    drive(BUS_LOAD, 32'h600, 0, BUS_NONE, 0, 10, 0, 0);
    expect_out(0, 10, 0);
    @(negedge clock);
    drive(BUS_NONE, 0, 0, BUS_LOAD, 32'h700, 11, 0, 0);
    expect_out(1, 11, 0);
    @(negedge clock);
    drive(BUS_LOAD, 32'h640, 64'h3, BUS_NONE, 0, 12, 10, 64'h5);
    #2 reset = 1'b0;
    #1;
    chk("t7_cmd", 64'(proc2mem_command), 64'd0);
    chk("t7_addr", 64'(proc2mem_addr), 64'd0);
    chk("t7_dresp", 64'(dcache_response), 64'd0);
    chk("t7_dtag", 64'(dcache_tag), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    dcache_command = BUS_NONE; mem2proc_response = 0; mem2proc_tag = 0;
    @(negedge clock);
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 10, 64'h6);
    @(negedge clock);
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 11, 64'h7);
    @(negedge clock);
    idle();
    chk("t7_tag_err", 64'(tag_err), 64'd1);
    pulse_reset();

    // Re-allocating a live tag sets tag_err.
    drive(BUS_LOAD, 32'h800, 0, BUS_NONE, 0, 9, 0, 0);
    expect_out(0, 9, 0);
    @(negedge clock);
    idle();
    chk("t6_tag_err_a", 64'(tag_err), 64'd0);
    drive(BUS_LOAD, 32'h900, 0, BUS_NONE, 0, 9, 0, 0);
    expect_out(0, 9, 0);
    @(negedge clock);
    idle();
    chk("t6_tag_err_b", 64'(tag_err), 64'd1);

    idle();
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
